// File: rtl/switch_debouncer_pkg.sv
// Shared types and default parameters for the switch debouncer.
// Optional feature macro: SWITCH_CHANGE_MASK_EN (adds CHANGED_MASK to the interface and core).
package switch_debouncer_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } state_e;

    localparam int DEF_WIDTH           = 16;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

    // Counter width that can hold DEBOUNCE_CYCLES-1, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : switch_debouncer_pkg

// File: rtl/switch_debouncer_if.sv
// Switch-word bundle between the raw pins / consumer and the debouncer core.
// Optional macro SWITCH_CHANGE_MASK_EN adds the CHANGED_MASK signal.
interface switch_debouncer_if
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] SWITCHES_RAW;
    logic [WIDTH-1:0] SWITCHES_STABLE;
    logic             UPDATE_PULSE;
    logic             BUSY;
`ifdef SWITCH_CHANGE_MASK_EN
    logic [WIDTH-1:0] CHANGED_MASK;

    modport master (
        output SWITCHES_RAW,
        input  SWITCHES_STABLE,
        input  UPDATE_PULSE,
        input  BUSY,
        input  CHANGED_MASK
    );

    modport slave (
        input  SWITCHES_RAW,
        output SWITCHES_STABLE,
        output UPDATE_PULSE,
        output BUSY,
        output CHANGED_MASK
    );
`else
    modport master (
        output SWITCHES_RAW,
        input  SWITCHES_STABLE,
        input  UPDATE_PULSE,
        input  BUSY
    );

    modport slave (
        input  SWITCHES_RAW,
        output SWITCHES_STABLE,
        output UPDATE_PULSE,
        output BUSY
    );
`endif

endinterface : switch_debouncer_if

// File: rtl/switch_debouncer_sync_chain.sv
// Per-bit multi-flop synchronizer bringing the raw switch pins into the CLK domain.
module sync_chain #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_d [SYNC_STAGES];
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value;
    // blocking ones would collapse the whole chain into a single flop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/switch_debouncer.sv
// Whole-word switch debouncer: synchronizes SWITCHES_RAW, commits a word once it has been
// steady for DEBOUNCE_CYCLES, and pulses UPDATE_PULSE on each change of the stable word.
// Optional macro SWITCH_CHANGE_MASK_EN adds a registered CHANGED_MASK (old XOR new word).
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               CLK,
    input  logic               RESET_N,
    switch_debouncer_if.slave  sw
);

    localparam int              CNT_W       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]      ST_IDLE     = 1'(IDLE);
    localparam logic [0:0]      ST_SETTLING = 1'(SETTLING);

    logic [WIDTH-1:0] sync_q;

    logic [0:0]       state_d,     state_q;
    logic [WIDTH-1:0] candidate_d, candidate_q;
    logic [CNT_W-1:0] cnt_d,       cnt_q;
    logic [WIDTH-1:0] stable_d,    stable_q;
    logic             pulse_d,     pulse_q;
    logic             busy_d,      busy_q;
`ifdef SWITCH_CHANGE_MASK_EN
    logic [WIDTH-1:0] mask_d,      mask_q;
`endif

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .din     (sw.SWITCHES_RAW),
        .dout    (sync_q)
    );

    // NOTE: every variable gets its hold value first so no branch can leave one unassigned
    // and infer a latch.
    always_comb begin
        state_d     = state_q;
        candidate_d = candidate_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        pulse_d     = 1'b0;
`ifdef SWITCH_CHANGE_MASK_EN
        mask_d      = mask_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sync_q != stable_q) begin
                    candidate_d = sync_q;
                    cnt_d       = '0;
                    state_d     = ST_SETTLING;
                end
            end

            ST_SETTLING: begin
                // A bounce on any bit restarts the count, even on the terminal cycle.
                if (sync_q != candidate_q) begin
                    candidate_d = sync_q;
                    cnt_d       = '0;
                end else if (cnt_q == CNT_LAST) begin
                    if (candidate_q != stable_q) begin
                        stable_d = candidate_q;
                        pulse_d  = 1'b1;
`ifdef SWITCH_CHANGE_MASK_EN
                        mask_d   = stable_q ^ candidate_q;
`endif
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SETTLING);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            candidate_q <= '0;
            cnt_q       <= '0;
            stable_q    <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            candidate_q <= candidate_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SWITCH_CHANGE_MASK_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign sw.CHANGED_MASK = mask_q;
`endif

    assign sw.SWITCHES_STABLE = stable_q;
    assign sw.UPDATE_PULSE    = pulse_q;
    assign sw.BUSY            = busy_q;

endmodule : switch_debouncer
